mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  EX->MEM stage directly downstream of the ALU. Captures ALU result, flags, store data, dest reg, instruction.
//  Drives data memory for loads/stores over a req/gnt/rvalid handshake; aligns and extends load data.
//  Suppresses writeback on ALU overflow. Stalls EX while a memory access is outstanding.
// PARAMETERS
//  AW  32  data-memory byte-address width; dmem_addr = ex_result[AW-1:0]
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  ex_valid       in   1   EX presents a valid instruction
//  ex_ready       out  1   stage can accept; transfer when ex_valid&ex_ready
//  ex_instr       in   32  instruction word; opcode = [31:26], func = [5:0]
//  ex_result      in   32  ALU result, or effective address for ld/st
//  ex_flags       in   3   {zero, neg, overflow} from ALU
//  ex_store_data  in   32  rt value for stores
//  ex_dest        in   5   destination register (rd or rt, resolved upstream)
//  flush          in   1   discard held/incoming instruction
//  dmem_req       out  1   memory request valid
//  dmem_we        out  1   1 = store
//  dmem_be        out  4   byte enables, lane i = addr[1:0]==i (little-endian)
//  dmem_addr      out  AW  byte address
//  dmem_wdata     out  32  store data replicated to lanes
//  dmem_gnt       in   1   request accepted this cycle
//  dmem_rvalid    in   1   load data valid
//  dmem_rdata     in   32  load data word
//  wb_valid       out  1   one-cycle pulse: WB fields valid
//  wb_we          out  1   register-file write enable
//  wb_dest        out  5   write register
//  wb_data        out  32  write data
//  exc_ovf        out  1   one-cycle pulse: add/addi/sub overflow, write suppressed
//  exc_misalign   out  1   one-cycle pulse: misaligned ld/st (only with MEM_ALIGN_TRAP_EN)
// BEHAVIOUR
//  Reset: state=IDLE; ex_ready=1; dmem_req/we=0; dmem_be=0; dmem_addr/wdata=0; wb_*=0; exc_*=0.
//  FSM: IDLE, REQ, WAIT. ex_ready = (state==IDLE).
//  IDLE, accept non-mem op: next edge wb_valid=1, wb_data=ex_result, wb_dest=ex_dest; latency 1, throughput 1/cycle.
//  wb_we = 1 unless ex_dest==0, op is store/branch (opcode 00010x), or overflow suppressed.
//  Overflow: ex_flags[0] & (opcode 001000 | opcode 0 & func 100000/100010) -> wb_we=0, exc_ovf=1 with wb_valid.
//  IDLE, accept mem op: register addr/be/wdata, dmem_req=1 next edge, go REQ.
//  REQ: hold req and all dmem_* stable until dmem_gnt. Store -> IDLE on gnt, wb_valid=1, wb_we=0. Load -> WAIT on gnt.
//  WAIT: on dmem_rvalid, wb_valid=1, wb_data = aligned/extended rdata -> IDLE. rvalid in same cycle as gnt not allowed.
//  Loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100. Stores: sw 101011, sh 101001, sb 101000.
//  Byte: lane addr[1:0], be=1<<addr[1:0]. Half: lane addr[1], be=0011/1100. Word: be=1111.
//  lb/lh sign-extend, lbu/lhu zero-extend.
//  flush in IDLE: incoming transfer dropped, no wb_valid.
//  flush in REQ: drop req next edge (aborts only if gnt not seen that cycle), -> IDLE, no wb.
//  flush in WAIT: must still consume rvalid, but wb_valid=0; flush overrides ex_valid same cycle.
//  rst_n low at any point: immediate return to reset values; outstanding access abandoned.
// CONFIGURATION
//  MEM_ALIGN_TRAP_EN defined: half addr[0]!=0 or word addr[1:0]!=0 -> no dmem_req; next edge wb_valid=1, wb_we=0, exc_misalign=1.
//  MEM_ALIGN_TRAP_EN undefined: low address bits forced to 0 for half/word; exc_misalign tied 0.
// STRUCTURE
//  Package mem_stage_pkg: opcode/func localparams, state enum {IDLE,REQ,WAIT}, size enum {SZ_B,SZ_H,SZ_W}.
//  Sub-module mem_lane_align: combinational be/wdata generation and load extract/extend; FSM and regs in top.
// TESTING
//  add, ex_result=0x0000_0005, ex_dest=8, flags=000 -> next cycle wb_valid=1, wb_we=1, wb_data=5.
//  addi with flags[0]=1 -> wb_valid=1, wb_we=0, exc_ovf=1 one cycle.
//  lb addr=0x103, rdata=0x80FF_0000, gnt after 2 stall cycles -> be=1000, ex_ready low throughout, wb_data=0xFFFF_FF80.
//  sh addr=0x202, store_data=0x0000_ABCD -> be=1100, wdata=0xABCD_ABCD, wb_valid=1, wb_we=0 on gnt.
//  lw in WAIT + flush, then rvalid -> wb_valid stays 0; rst_n low in REQ -> dmem_req 0 immediately.
//  MEM_ALIGN_TRAP_EN: lw addr=0x102 -> no dmem_req, exc_misalign=1; undefined: dmem_addr=0x100.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the EX->MEM stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OPC_W  = 6;
  localparam int unsigned BE_W   = 4;

  localparam logic [OPC_W-1:0] OP_SPECIAL = 6'b000000;
  localparam logic [OPC_W-1:0] OP_ADDI    = 6'b001000;
  localparam logic [OPC_W-1:0] OP_LB      = 6'b100000;
  localparam logic [OPC_W-1:0] OP_LH      = 6'b100001;
  localparam logic [OPC_W-1:0] OP_LW      = 6'b100011;
  localparam logic [OPC_W-1:0] OP_LBU     = 6'b100100;
  localparam logic [OPC_W-1:0] OP_LHU     = 6'b100101;
  localparam logic [OPC_W-1:0] OP_SB      = 6'b101000;
  localparam logic [OPC_W-1:0] OP_SH      = 6'b101001;
  localparam logic [OPC_W-1:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // Memory-access attributes carried from accept to completion.
  typedef struct packed {
    logic  is_load;
    logic  is_store;
    size_e size;
    logic  sign;
  } mem_op_t;

  // Classify an opcode as load/store with its access size and extension.
  function automatic mem_op_t decode_mem(input logic [OPC_W-1:0] opcode);
    mem_op_t m;
    m = '{is_load: 1'b0, is_store: 1'b0, size: SZ_W, sign: 1'b0};
    case (opcode)
      OP_LW:   m.is_load = 1'b1;
      OP_LH:   begin m.is_load = 1'b1; m.size = SZ_H; m.sign = 1'b1; end
      OP_LHU:  begin m.is_load = 1'b1; m.size = SZ_H; end
      OP_LB:   begin m.is_load = 1'b1; m.size = SZ_B; m.sign = 1'b1; end
      OP_LBU:  begin m.is_load = 1'b1; m.size = SZ_B; end
      OP_SW:   m.is_store = 1'b1;
      OP_SH:   begin m.is_store = 1'b1; m.size = SZ_H; end
      OP_SB:   begin m.is_store = 1'b1; m.size = SZ_B; end
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / data replication and load extract / extend.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  input  size_e       ld_size,
  input  logic        ld_sign,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] ld_data_c
);

  logic [31:0] shifted;

  // Store side: lane enables and data replicated into every lane.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = st_data;
    case (st_size)
      SZ_B: begin
        be_c    = 4'(1) << st_addr_lo;
        wdata_c = {4{st_data[7:0]}};
      end
      SZ_H: begin
        be_c    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: shift the addressed lane down, then sign- or zero-extend.
  always_comb begin
    shifted   = rdata >> {ld_addr_lo, 3'b000};
    ld_data_c = rdata;
    case (ld_size)
      SZ_B: ld_data_c = ld_sign ? {{24{shifted[7]}}, shifted[7:0]}
                                : {24'h0, shifted[7:0]};
      SZ_H: ld_data_c = ld_sign ? {{16{shifted[15]}}, shifted[15:0]}
                                : {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// EX->MEM stage: writeback for ALU ops, req/gnt/rvalid data-memory access for ld/st.
// Optional feature macro: MEM_ALIGN_TRAP_EN (trap misaligned half/word accesses).
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [31:0]   ex_instr,
  input  logic [31:0]   ex_result,
  input  logic [2:0]    ex_flags,
  input  logic [31:0]   ex_store_data,
  input  logic [4:0]    ex_dest,
  input  logic          flush,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [3:0]    dmem_be,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_wdata,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [31:0]   dmem_rdata,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [4:0]    wb_dest,
  output logic [31:0]   wb_data,
  output logic          exc_ovf,
  output logic          exc_misalign
);

  state_e state, state_nxt;

  logic [OPC_W-1:0] opcode;
  logic [5:0]       func;
  mem_op_t          cur_op, op_q, op_d;
  logic             is_mem, accept, ovf, branch, trap;
  logic [AW-1:0]    addr_mask, addr_aligned;
  logic [REG_W-1:0] dest_q, dest_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic             kill_q, kill_d;

  logic              dmem_req_d, dmem_we_d;
  logic [BE_W-1:0]   dmem_be_d;
  logic [AW-1:0]     dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_d;
  logic              wb_valid_d, wb_we_d;
  logic [REG_W-1:0]  wb_dest_d;
  logic [DATA_W-1:0] wb_data_d;
  logic              exc_ovf_d, exc_mis_d;

  logic [3:0]        be_c;
  logic [31:0]       wdata_c, ld_data_c;

  logic unused_bits;
  assign unused_bits = ^{ex_instr[25:6], ex_flags[2:1]};

  assign opcode = ex_instr[31:26];
  assign func   = ex_instr[5:0];
  assign cur_op = decode_mem(opcode);
  assign is_mem = cur_op.is_load | cur_op.is_store;
  assign accept = ex_valid & (state == IDLE) & ~flush;
  assign branch = (opcode[5:1] == 5'b00010);
  assign ovf    = ex_flags[0] & ((opcode == OP_ADDI) |
                  ((opcode == OP_SPECIAL) & ((func == FN_ADD) | (func == FN_SUB))));

  // Half/word accesses ignore (or trap on) the low address bits.
  always_comb begin
    addr_mask = '0;
    case (cur_op.size)
      SZ_W:    addr_mask = AW'(3);
      SZ_H:    addr_mask = AW'(1);
      default: ;
    endcase
  end
  assign addr_aligned = ex_result[AW-1:0] & ~addr_mask;

`ifdef MEM_ALIGN_TRAP_EN
  assign trap = is_mem & (((cur_op.size == SZ_H) & ex_result[0]) |
                          ((cur_op.size == SZ_W) & (ex_result[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  mem_lane_align u_align (
    .st_size    (cur_op.size),
    .st_addr_lo (addr_aligned[1:0]),
    .st_data    (ex_store_data),
    .ld_size    (op_q.size),
    .ld_sign    (op_q.sign),
    .ld_addr_lo (addr_lo_q),
    .rdata      (dmem_rdata),
    .be_c       (be_c),
    .wdata_c    (wdata_c),
    .ld_data_c  (ld_data_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_mem && !trap) state_nxt = REQ;
      REQ: begin
        if (dmem_gnt)   state_nxt = op_q.is_store ? IDLE : WAIT;
        else if (flush) state_nxt = IDLE;
      end
      WAIT: if (dmem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and held access context.
  always_comb begin
    dmem_req_d   = dmem_req;
    dmem_we_d    = dmem_we;
    dmem_be_d    = dmem_be;
    dmem_addr_d  = dmem_addr;
    dmem_wdata_d = dmem_wdata;
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    wb_dest_d    = wb_dest;
    wb_data_d    = wb_data;
    exc_ovf_d    = 1'b0;
    exc_mis_d    = 1'b0;
    op_d         = op_q;
    dest_d       = dest_q;
    addr_lo_d    = addr_lo_q;
    kill_d       = kill_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = (ex_dest != 5'd0) & ~branch & ~ovf;
            wb_dest_d  = ex_dest;
            wb_data_d  = ex_result;
            exc_ovf_d  = ovf;
          end else if (trap) begin
            wb_valid_d = 1'b1;
            wb_dest_d  = ex_dest;
            wb_data_d  = ex_result;
            exc_mis_d  = 1'b1;
          end else begin
            dmem_req_d   = 1'b1;
            dmem_we_d    = cur_op.is_store;
            dmem_be_d    = be_c;
            dmem_addr_d  = addr_aligned;
            dmem_wdata_d = wdata_c;
            op_d         = cur_op;
            dest_d       = ex_dest;
            addr_lo_d    = addr_aligned[1:0];
            kill_d       = 1'b0;
          end
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          // A granted access has happened; a same-cycle flush only hides its result.
          dmem_req_d = 1'b0;
          kill_d     = flush;
          if (op_q.is_store && !flush) begin
            wb_valid_d = 1'b1;
            wb_dest_d  = dest_q;
          end
        end else if (flush) begin
          dmem_req_d = 1'b0;
        end
      end
      WAIT: begin
        if (flush) kill_d = 1'b1;
        if (dmem_rvalid && !kill_q && !flush) begin
          wb_valid_d = 1'b1;
          wb_we_d    = (dest_q != 5'd0);
          wb_dest_d  = dest_q;
          wb_data_d  = ld_data_c;
        end
      end
      default: ;
    endcase
  end

  // Output and context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ready   <= 1'b1;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_dest    <= '0;
      wb_data    <= '0;
      exc_ovf    <= 1'b0;
      op_q       <= '{is_load: 1'b0, is_store: 1'b0, size: SZ_W, sign: 1'b0};
      dest_q     <= '0;
      addr_lo_q  <= '0;
      kill_q     <= 1'b0;
    end else begin
      ex_ready   <= (state_nxt == IDLE);
      dmem_req   <= dmem_req_d;
      dmem_we    <= dmem_we_d;
      dmem_be    <= dmem_be_d;
      dmem_addr  <= dmem_addr_d;
      dmem_wdata <= dmem_wdata_d;
      wb_valid   <= wb_valid_d;
      wb_we      <= wb_we_d;
      wb_dest    <= wb_dest_d;
      wb_data    <= wb_data_d;
      exc_ovf    <= exc_ovf_d;
      op_q       <= op_d;
      dest_q     <= dest_d;
      addr_lo_q  <= addr_lo_d;
      kill_q     <= kill_d;
    end
  end

`ifdef MEM_ALIGN_TRAP_EN
  // Misalignment exception pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exc_misalign <= 1'b0;
    else        exc_misalign <= exc_mis_d;
  end
`else
  logic unused_mis;
  assign unused_mis   = exc_mis_d;
  assign exc_misalign = 1'b0;
`endif

endmodule
